// File: rtl/if_fetch_buffer.sv
// Instruction-fetch front end: builds INST_W-bit instructions from MEM_W-bit
// memory beats (or takes them whole from the icache on a hit), queues
// {pc, inst} pairs in a small prefetch FIFO and hands them to decode.
// A redirect flushes the FIFO and restarts fetch at the new PC; the response
// to a request still in flight at that moment is dropped.
module if_fetch_buffer #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int MEM_W  = 8,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              icache_hit,
  input  logic [INST_W-1:0] icache_inst,
  output logic [ADDR_W-1:0] icache_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [MEM_W-1:0]  mem_rdata,
  input  logic              mem_rvalid,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              busy
);

  localparam int BEATS  = INST_W / MEM_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STEP_A       = ADDR_W'(INST_W / 8);
  localparam logic [ADDR_W-1:0] BEAT_BYTES_A = ADDR_W'(MEM_W / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT    = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C      = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_discard;
  logic                r_mem_req;
  logic                r_busy;
  logic [INST_W-1:0]   r_asm;
  logic [ADDR_W-1:0]   r_fifo_pc   [DEPTH];
  logic [INST_W-1:0]   r_fifo_inst [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_id_valid;
  logic                w_pop;
  logic                w_has_room;
  logic                w_idle;
  logic                w_hit_push;
  logic                w_miss_start;
  logic                w_beat_done;
  logic                w_asm_push;
  logic                w_push;
  logic [INST_W-1:0]   w_asm_next;
  logic [INST_W-1:0]   w_push_inst;

  assign icache_pc = r_fetch_pc;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_fetch_pc + (ADDR_W'(r_beat) * BEAT_BYTES_A);
  assign busy      = r_busy;
  assign id_valid  = w_id_valid;
  assign id_pc     = r_fifo_pc[r_rd_ptr];
  assign id_inst   = r_fifo_inst[r_rd_ptr];

  // Head is hidden from decode in the cycle a redirect flushes the queue.
  assign w_id_valid   = (r_count != {CNT_W{1'b0}}) && !redirect;
  assign w_pop        = w_id_valid && id_ready;
  assign w_has_room   = (r_count < DEPTH_C);
  assign w_idle       = (r_state == S_IDLE);
  // A hit may refill the slot freed by a pop in the same cycle.
  assign w_hit_push   = !redirect && w_idle && icache_hit && (w_has_room || w_pop);
  // A miss only starts with a free slot, so its final push always fits.
  assign w_miss_start = !redirect && w_idle && !icache_hit && w_has_room && !r_discard;
  assign w_beat_done  = !redirect && (r_state == S_WAIT) && mem_rvalid && !r_discard;
  assign w_asm_push   = w_beat_done && (r_beat == LAST_BEAT);
  assign w_push       = w_hit_push || w_asm_push;
  assign w_push_inst  = w_hit_push ? icache_inst : w_asm_next;

  // Merge the returning beat into its little-endian slot of the instruction.
  always_comb begin
    w_asm_next = r_asm;
    for (int k = 0; k < BEATS; k++) begin
      if (r_beat == BEAT_W'(k)) begin
        w_asm_next[k*MEM_W +: MEM_W] = mem_rdata;
      end else begin
        w_asm_next[k*MEM_W +: MEM_W] = r_asm[k*MEM_W +: MEM_W];
      end
    end
  end

  // Fetch FSM: fetch PC, beat counter, discard flag and registered request/busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_beat     <= {BEAT_W{1'b0}};
      r_discard  <= 1'b0;
      r_mem_req  <= 1'b0;
      r_busy     <= 1'b0;
      r_asm      <= {INST_W{1'b0}};
    end else begin
      // A stale response retires the discard; otherwise a redirect with a
      // request in flight arms it (an in-cycle response needs no discard).
      if (r_discard && mem_rvalid) begin
        r_discard <= 1'b0;
      end else if (redirect && ((r_state == S_REQ) || ((r_state == S_WAIT) && !mem_rvalid))) begin
        r_discard <= 1'b1;
      end

      if (redirect) begin
        r_state    <= S_IDLE;
        r_fetch_pc <= redirect_pc;
        r_beat     <= {BEAT_W{1'b0}};
        r_mem_req  <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_hit_push) begin
              r_fetch_pc <= r_fetch_pc + STEP_A;
            end else if (w_miss_start) begin
              r_state   <= S_REQ;
              r_beat    <= {BEAT_W{1'b0}};
              r_mem_req <= 1'b1;
            end
          end
          S_REQ: begin
            r_state   <= S_WAIT;
            r_mem_req <= 1'b0;
            r_busy    <= 1'b1;
          end
          S_WAIT: begin
            if (w_beat_done) begin
              r_asm  <= w_asm_next;
              r_busy <= 1'b0;
              if (r_beat == LAST_BEAT) begin
                r_state    <= S_IDLE;
                r_fetch_pc <= r_fetch_pc + STEP_A;
                r_beat     <= {BEAT_W{1'b0}};
              end else begin
                r_state   <= S_REQ;
                r_beat    <= r_beat + BEAT_W'(1);
                r_mem_req <= 1'b1;
              end
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_beat    <= {BEAT_W{1'b0}};
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // FIFO storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
      r_fifo_inst[r_wr_ptr] <= w_push_inst;
    end
  end

endmodule
